// File: rtl/GPU_Shader_pkg.sv
// Types shared across the GPU shader blocks: memory word, add-engine job
// descriptor and the job scheduler state encoding.
package GPU_Shader_pkg;

   typedef logic [31:0] word_t;
   localparam int MEM_DEPTH = 1024;

   typedef struct packed {
      word_t baseA;
      word_t baseB;
      word_t baseC;
      word_t length;
   } job_t;

   typedef enum logic [1:0] {
      IDLE,
      START,
      RELEASE,
      CMPL
   } sched_state_t;

endpackage

// File: rtl/matadd_job_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requesting index after last_grant,
// wrapping at NREQ.
module rr_arbiter #(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] last_grant,
   output logic [$clog2(NREQ)-1:0] grant,
   output logic                    grant_valid
);

   localparam int GW = $clog2(NREQ);

   logic [GW-1:0] idx;

   // NOTE: every variable gets a default before the search, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      idx         = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = GW'((int'(last_grant) + k) % NREQ);
         if (!grant_valid && req[idx]) begin
            grant       = idx;
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/matadd_job_scheduler.sv
// Shares one matrix-add engine among NREQ requesters: one job slot each,
// round-robin dispatch, start/done handshake with a watchdog timeout.
module matadd_job_scheduler
   import GPU_Shader_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 4096
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  job_t [NREQ-1:0]         req_job,
   output logic [NREQ-1:0]         cmpl_valid,
   output logic                    cmpl_err,
   output logic                    eng_start,
   output logic [31:0]             eng_baseA,
   output logic [31:0]             eng_baseB,
   output logic [31:0]             eng_baseC,
   output logic [31:0]             eng_length,
   input  logic                    eng_busy,
   input  logic                    eng_done,
   output logic                    sched_busy,
   output logic [$clog2(NREQ)-1:0] grant_id
);

   localparam int              GW      = $clog2(NREQ);
   localparam int              WW      = $clog2(TIMEOUT) + 1;
   localparam logic [WW-1:0]   WD_LAST = WW'(TIMEOUT - 1);
   localparam logic [WW-1:0]   WD_MAX  = '1;

   sched_state_t    state, next_state;
   logic [NREQ-1:0] slot_valid;
   job_t            slot_job [NREQ];
   job_t            eng_job;
   logic [GW-1:0]   last_grant;
   logic [GW-1:0]   arb_grant;
   logic            arb_valid;
   logic            err;
   logic            timeout_hit;
   logic [WW-1:0]   watchdog;
   logic [NREQ-1:0] accept;
   logic            unused_eng_busy;

   assign unused_eng_busy = eng_busy;

   // Ready comes straight off the slot flops, so a slot freed in CMPL
   // only reopens the cycle after.
   assign req_ready   = ~slot_valid;
   assign accept      = req_valid & ~slot_valid;
   assign timeout_hit = (state == START) && !eng_done && (watchdog == WD_LAST);

   assign eng_baseA  = eng_job.baseA;
   assign eng_baseB  = eng_job.baseB;
   assign eng_baseC  = eng_job.baseC;
   assign eng_length = eng_job.length;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req         (slot_valid),
      .last_grant  (last_grant),
      .grant       (arb_grant),
      .grant_valid (arb_valid)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      eng_start  = 1'b0;
      cmpl_valid = '0;
      cmpl_err   = 1'b0;
      sched_busy = (state != IDLE) || (|slot_valid);
      case (state)
         IDLE: begin
            if (arb_valid)
               next_state = (slot_job[arb_grant].length == '0) ? CMPL : START;
         end
         START: begin
            eng_start = 1'b1;
            if (eng_done || (watchdog == WD_LAST)) next_state = RELEASE;
         end
         RELEASE: begin
            if (err || !eng_done) next_state = CMPL;
         end
         CMPL: begin
            cmpl_valid[grant_id] = 1'b1;
            cmpl_err             = err;
            next_state           = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // NOTE: job payload storage has no reset; slot_valid alone decides whether an entry is meaningful.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NREQ; i++)
         if (accept[i]) slot_job[i] <= req_job[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_valid <= '0;
         last_grant <= GW'(NREQ - 1);
         err        <= 1'b0;
         watchdog   <= '0;
         eng_job    <= '0;
         grant_id   <= '0;
      end else begin
         // accept and clear can never hit the same slot: accept needs it empty
         slot_valid <= (slot_valid | accept) & ~cmpl_valid;
         case (state)
            IDLE: begin
               if (arb_valid) begin
                  eng_job  <= slot_job[arb_grant];
                  grant_id <= arb_grant;
                  watchdog <= '0;
               end
            end
            START: begin
               if (watchdog != WD_MAX) watchdog <= watchdog + 1'b1;
               if (timeout_hit) err <= 1'b1;
            end
            CMPL: begin
               last_grant <= grant_id;
               err        <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/matadd_job_scheduler.md
MATADD_JOB_SCHEDULER -- requirements
Module: matadd_job_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 4096, maximum cycles waiting for eng_done before error completion.
REQ-003 SHALL have port clk  in  1  clock; reset rst_n, asynchronous, active-low.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  in  NREQ  per-requester job offer.
REQ-006 SHALL have port req_ready  out  NREQ  per-requester slot free.
REQ-007 SHALL have port req_job  in  NREQ x job_t  per-requester job {baseA, baseB, baseC (32b each), length (32b)}.
REQ-008 SHALL have port cmpl_valid  out  NREQ  one-cycle completion pulse per requester.
REQ-009 SHALL have port cmpl_err  out  1  completion was a timeout; qualified by any cmpl_valid.
REQ-010 SHALL have port eng_start  out  1  start level to add engine.
REQ-011 SHALL have port eng_baseA, eng_baseB, eng_baseC, eng_length  out  32 each  job fields to engine.
REQ-012 SHALL have port eng_busy, eng_done  in  1 each  engine status.
REQ-013 SHALL have port sched_busy  out  1  state != IDLE or any slot valid.
REQ-014 SHALL have port grant_id  out  $clog2(NREQ)  requester currently owning the engine.

Function
REQ-015 SHALL hold one job slot per requester; req_ready[i] = !slot_valid[i] (registered); accept on req_valid[i] & req_ready[i] at clk edge.
REQ-016 SHALL implement FSM states IDLE, START, RELEASE, CMPL.
REQ-017 IDLE: if any slot valid, SHALL grant round-robin starting at last_grant+1 (wrapping at NREQ), register job onto eng_* and grant_id; length==0 -> CMPL, else -> START.
REQ-018 START: eng_start SHALL be 1; on eng_done==1 -> RELEASE; watchdog counts cycles in START and at count TIMEOUT-1 SHALL set err flag and -> RELEASE.
REQ-019 RELEASE: eng_start SHALL be 0; on eng_done==0 -> CMPL (error case goes to CMPL next cycle unconditionally).
REQ-020 CMPL: cmpl_valid[grant_id] SHALL pulse one cycle with cmpl_err=err, clear slot_valid[grant_id], update last_grant, clear err, -> IDLE.
REQ-021 Job accepted at edge E with FSM in IDLE and no other slot valid SHALL see eng_start=1 from edge E+2.
REQ-022 eng_* fields SHALL remain stable from grant until CMPL exit.
REQ-023 A slot cleared in CMPL SHALL not accept a new job in that same cycle (ready rises next cycle).
REQ-024 Requests arriving during START/RELEASE SHALL be latched but not granted until IDLE.
REQ-025 Watchdog SHALL be $clog2(TIMEOUT)+1 bits and saturate; reset to 0 on entry to START.
REQ-026 A requester SHALL never receive two consecutive grants while another slot is valid.

Reset
REQ-027 On rst_n low SHALL force state=IDLE, slot_valid=0, last_grant=NREQ-1, err=0, watchdog=0, eng_start=0, eng_*=0, grant_id=0, cmpl_valid=0, cmpl_err=0.
REQ-028 Reset mid-job SHALL drop all pending and in-flight jobs without any completion pulse.

Structure
REQ-029 job_t struct and sched_state_t enum SHALL be added to GPU_Shader_pkg alongside word_t/MEM_DEPTH.
REQ-030 Round-robin arbiter SHALL be a sub-module rr_arbiter (inputs req vector, last_grant; output grant index, grant valid), combinational.

Verification
REQ-031 Single job {A=0,B=64,C=128,len=16}, requester 0 -> eng_start high from E+2, cmpl_valid[0] once, cmpl_err=0.
REQ-032 Both requesters valid same cycle after reset -> grants 0 then 1 then 0 (repeat loading) alternate; no back-to-back same grant.
REQ-033 len=0 job -> no eng_start asserted; cmpl_valid pulse 2 cycles after acceptance.
REQ-034 Engine model never asserts done, TIMEOUT=16 -> cmpl_valid with cmpl_err=1 at 16th START cycle +2; next job proceeds normally.
REQ-035 rst_n low during START -> eng_start=0, req_ready all 1 after reset release, no cmpl_valid.
REQ-036 Requester re-offers in its CMPL cycle -> not accepted that cycle, accepted next cycle.
